ahb_burst_addr_gen: RTL and testbench

//  Parametrised AHB-Lite master-side burst address/control generator.

---
 rtl/ahb3lite_pkg.sv | 56 +++++
 rtl/ahb_addr_step.sv | 40 ++++
 rtl/ahb_burst_addr_gen.sv | 194 +++++++++++++++++++
 tb/tb_ahb_burst_addr_gen.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb3lite_pkg.sv
// ahb3lite_pkg: shared AHB-Lite encodings and helpers for the burst address generator.
//   - HTRANS / HBURST encodings
//   - burst_state_t : FSM states of the burst generator
//   - burst_beats() : beat count of a burst type
//   - max_size()    : largest legal HSIZE for a given bus data width
//   - burst_is_wrap() / burst_is_incr() : burst classification
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    typedef enum logic [2:0] {
        BS_IDLE,
        BS_ADDR,
        BS_BUSY,
        BS_LAST,
        BS_ERR
    } burst_state_t;

    function automatic int unsigned burst_beats(input logic [2:0] hburst, input int unsigned incr_len);
        int unsigned n;
        case (hburst)
            HBURST_SINGLE:              n = 1;
            HBURST_INCR:                n = (incr_len == 0) ? 1 : incr_len;
            HBURST_WRAP4, HBURST_INCR4: n = 4;
            HBURST_WRAP8, HBURST_INCR8: n = 8;
            default:                    n = 16;
        endcase
        return n;
    endfunction

    function automatic int unsigned max_size(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic logic burst_is_wrap(input logic [2:0] hburst);
        return (hburst != HBURST_SINGLE) && !hburst[0];
    endfunction

    // INCR, INCR4, INCR8, INCR16 all have an odd encoding.
    function automatic logic burst_is_incr(input logic [2:0] hburst);
        return hburst[0];
    endfunction

endpackage

// File: rtl/ahb_addr_step.sv
// ahb_addr_step: combinational next-beat address for an AHB burst.
// Ports:
//   i_addr     current beat address
//   i_size     HSIZE of the burst (step = 1 << size)
//   i_burst    HBURST of the burst (selects incrementing or wrapping)
//   i_beats    beat count of the burst (sets the wrap block size)
//   o_next     address of the following beat
//   o_kb_cross incrementing step lands on a 1 KB boundary
module ahb_addr_step
    import ahb3lite_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 5
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [2:0]        i_size,
    input  logic [2:0]        i_burst,
    input  logic [CNT_W-1:0]  i_beats,
    output logic [ADDR_W-1:0] o_next,
    output logic              o_kb_cross
);

    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_inc;
    logic [ADDR_W-1:0] w_mask;

    always_comb begin
        w_step = ADDR_W'(1) << i_size;
        w_inc  = i_addr + w_step;
        // Wrap block is beats*step bytes; both are powers of two so the mask is a simple decrement.
        w_mask = (ADDR_W'(i_beats) << i_size) - ADDR_W'(1);
        if (burst_is_wrap(i_burst)) begin
            o_next = (i_addr & ~w_mask) | (w_inc & w_mask);
        end else begin
            o_next = w_inc;
        end
        o_kb_cross = burst_is_incr(i_burst) && (w_inc[9:0] == 10'd0);
    end

endmodule

// File: rtl/ahb_burst_addr_gen.sv
// ahb_burst_addr_gen: AHB-Lite master-side burst address/control generator.
// Handles SINGLE, INCR (length incr_len), INCR4/8/16 and WRAP4/8/16 at any legal HSIZE,
// honours HREADY wait states and ERROR responses, and inserts BUSY on busy_req.
// Optional build macro: KB_BOUNDARY_EN -- incrementing beats that land on a 1 KB
// boundary are re-issued as NONSEQ with HBURST forced to INCR.
// Ports:
//   HCLK, HRESET        clock, synchronous active-high reset
//   start, start_addr   burst request and first-beat address (taken only while rdy=1)
//   burst, size, write  HBURST / HSIZE / HWRITE of the request
//   incr_len            beat count for HBURST_INCR (0 means 1)
//   busy_req            insert a BUSY cycle before the next SEQ beat
//   HREADY, HRESP       slave handshake
//   HADDR, HTRANS, HBURST, HSIZE, HWRITE   address-phase outputs
//   rdy                 idle and able to accept start
//   done                pulse: final data phase completed OK
//   err                 pulse: ERROR response or illegal request
//   beat_idx            index of the beat in its address phase
module ahb_burst_addr_gen
    import ahb3lite_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 5
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [2:0]        burst,
    input  logic [2:0]        size,
    input  logic              write,
    input  logic [LEN_W-1:0]  incr_len,
    input  logic              busy_req,
    input  logic              HREADY,
    input  logic              HRESP,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HBURST,
    output logic [2:0]        HSIZE,
    output logic              HWRITE,
    output logic              rdy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  beat_idx
);

    // Counter must hold 16 beats even if incr_len is narrow.
    localparam int         CNT_W  = (LEN_W > 5) ? LEN_W : 5;
    localparam logic [2:0] MAX_SZ = 3'(max_size(DATA_W));

    burst_state_t      r_state;
    burst_state_t      w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_burst;
    logic [2:0]        r_size;
    logic              r_write;
    logic [CNT_W-1:0]  r_beats;
    logic [CNT_W-1:0]  r_idx;
    logic              r_nonseq;
    logic              r_req_err;

    logic [ADDR_W-1:0] w_align_mask;
    logic              w_req_legal;
    logic              w_accept;
    logic              w_advance;
    logic              w_last_beat;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_kb_cross;

    ahb_addr_step #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_step (
        .i_addr     (r_addr),
        .i_size     (r_size),
        .i_burst    (r_burst),
        .i_beats    (r_beats),
        .o_next     (w_next_addr),
        .o_kb_cross (w_kb_cross)
    );

`ifndef KB_BOUNDARY_EN
    logic w_unused_kb;
    assign w_unused_kb = w_kb_cross;
`endif

    assign w_align_mask = (ADDR_W'(1) << size) - ADDR_W'(1);
    assign w_req_legal  = (size <= MAX_SZ) && ((start_addr & w_align_mask) == '0);
    assign w_accept     = (r_state == BS_IDLE) && start && w_req_legal;
    assign w_last_beat  = (r_idx == r_beats - CNT_W'(1));

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= BS_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_advance    = 1'b0;
        HTRANS       = HTRANS_IDLE;
        rdy          = 1'b0;
        done         = 1'b0;
        err          = r_req_err;
        case (r_state)
            BS_IDLE: begin
                rdy = 1'b1;
                if (w_accept) begin
                    w_next_state = BS_ADDR;
                end
            end
            BS_ADDR: begin
                HTRANS = r_nonseq ? HTRANS_NONSEQ : HTRANS_SEQ;
                if (HREADY) begin
                    if (w_last_beat) begin
                        w_next_state = BS_LAST;
                    end else begin
                        w_advance    = 1'b1;
                        w_next_state = busy_req ? BS_BUSY : BS_ADDR;
                    end
                end
            end
            BS_BUSY: begin
                HTRANS = HTRANS_BUSY;
                if (HREADY && !busy_req) begin
                    w_next_state = BS_ADDR;
                end
            end
            BS_LAST: begin
                if (HREADY) begin
                    done         = !HRESP;
                    w_next_state = BS_IDLE;
                end
            end
            BS_ERR: begin
                err          = 1'b1;
                w_next_state = BS_IDLE;
            end
            default: begin
                w_next_state = BS_IDLE;
            end
        endcase
        // First cycle of a two-cycle ERROR: cancel the rest of the burst.
        // IDLE has no outstanding data phase, so the response is ignored there.
        if ((r_state != BS_IDLE) && (r_state != BS_ERR) && !HREADY && HRESP) begin
            w_next_state = BS_ERR;
            w_advance    = 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_addr    <= '0;
            r_burst   <= HBURST_SINGLE;
            r_size    <= '0;
            r_write   <= 1'b0;
            r_beats   <= '0;
            r_idx     <= '0;
            r_nonseq  <= 1'b0;
            r_req_err <= 1'b0;
        end else begin
            r_req_err <= (r_state == BS_IDLE) && start && !w_req_legal;
            if (w_accept) begin
                r_addr   <= start_addr;
                r_burst  <= burst;
                r_size   <= size;
                r_write  <= write;
                r_beats  <= CNT_W'(burst_beats(burst, 32'(incr_len)));
                r_idx    <= '0;
                r_nonseq <= 1'b1;
            end else if (w_advance) begin
                r_addr   <= w_next_addr;
                r_idx    <= r_idx + CNT_W'(1);
                r_nonseq <= 1'b0;
`ifdef KB_BOUNDARY_EN
                // Slaves may not see a burst across 1 KB; restart it as an undefined-length INCR.
                if (w_kb_cross) begin
                    r_nonseq <= 1'b1;
                    r_burst  <= HBURST_INCR;
                end
`endif
            end
        end
    end

    assign HADDR    = r_addr;
    assign HBURST   = r_burst;
    assign HSIZE    = r_size;
    assign HWRITE   = r_write;
    assign beat_idx = r_idx[LEN_W-1:0];

endmodule

// File: tb/tb_ahb_burst_addr_gen.sv
// tb_ahb_burst_addr_gen: scoreboard bench for ahb_burst_addr_gen.
// Each accepted address phase (HTRANS != IDLE with HREADY=1) is popped from a queue of
// expected {HADDR, HTRANS, HBURST, beat_idx}; scenario tasks check pulses, holds and idle state.
module tb_ahb_burst_addr_gen;

    logic        HCLK;
    logic        HRESET;
    logic        start;
    logic [15:0] start_addr;
    logic [2:0]  burst;
    logic [2:0]  size;
    logic        write;
    logic [4:0]  incr_len;
    logic        busy_req;
    logic        HREADY;
    logic        HRESP;
    logic [15:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic        rdy;
    logic        done;
    logic        err;
    logic [4:0]  beat_idx;

    ahb_burst_addr_gen #(
        .ADDR_W (16),
        .DATA_W (32),
        .LEN_W  (5)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .start      (start),
        .start_addr (start_addr),
        .burst      (burst),
        .size       (size),
        .write      (write),
        .incr_len   (incr_len),
        .busy_req   (busy_req),
        .HREADY     (HREADY),
        .HRESP      (HRESP),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HBURST     (HBURST),
        .HSIZE      (HSIZE),
        .HWRITE     (HWRITE),
        .rdy        (rdy),
        .done       (done),
        .err        (err),
        .beat_idx   (beat_idx)
    );

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    typedef struct packed {
        logic [15:0] addr;
        logic [1:0]  trans;
        logic [2:0]  hburst;
        logic [4:0]  idx;
    } beat_t;

    beat_t       exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] log_addr  [64];
    logic [1:0]  log_trans [64];

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1);
    end

    function automatic beat_t mk(input logic [15:0] a, input logic [1:0] t, input logic [2:0] b, input int i);
        beat_t e;
        e.addr   = a;
        e.trans  = t;
        e.hburst = b;
        e.idx    = 5'(i);
        return e;
    endfunction

    // Scoreboard: every accepted address phase must match the head of the queue.
    always @(negedge HCLK) begin
        if (!HRESET && HTRANS != T_IDLE && HREADY) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL beat_unexpected: got addr=%h trans=%0d burst=%0d idx=%0d, required none",
                         HADDR, HTRANS, HBURST, beat_idx);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                if ({HADDR, HTRANS, HBURST, beat_idx} !== e) begin
                    n_bad++;
                    $display("FAIL beat: got addr=%h trans=%0d burst=%0d idx=%0d, required addr=%h trans=%0d burst=%0d idx=%0d",
                             HADDR, HTRANS, HBURST, beat_idx, e.addr, e.trans, e.hburst, e.idx);
                end
            end
        end
    end

    task automatic do_start(input logic [15:0] a, input logic [2:0] b, input logic [2:0] s,
                            input logic w, input logic [4:0] l);
        start_addr = a;
        burst      = b;
        size       = s;
        write      = w;
        incr_len   = l;
        start      = 1'b1;
        @(posedge HCLK);
        #1;
        start      = 1'b0;
    endtask

    // Drives a fixed number of cycles; called at posedge+1, returns at posedge+1.
    task automatic run_cycles(input int ncyc, input int stall_at, input int stall_n, input int busy_at,
                              input int err_at, output int n_done, output int n_err);
        n_done = 0;
        n_err  = 0;
        for (int c = 0; c < ncyc; c++) begin
            HREADY   = !(c >= stall_at && c < stall_at + stall_n);
            busy_req = (c == busy_at);
            HRESP    = 1'b0;
            if (err_at >= 0 && c == err_at) begin
                HREADY = 1'b0;
                HRESP  = 1'b1;
            end else if (err_at >= 0 && c == err_at + 1) begin
                HREADY = 1'b1;
                HRESP  = 1'b1;
            end
            @(negedge HCLK);
            log_addr[c]  = HADDR;
            log_trans[c] = HTRANS;
            if (done) n_done++;
            if (err) n_err++;
            @(posedge HCLK);
            #1;
        end
        HREADY   = 1'b1;
        HRESP    = 1'b0;
        busy_req = 1'b0;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        n_vec++;
        if ({HADDR, HTRANS, HBURST, HSIZE, HWRITE, rdy, done, err, beat_idx} !==
            {16'h0, T_IDLE, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0}) begin
            n_bad++;
            $display("FAIL reset_state: got addr=%h trans=%0d burst=%0d size=%0d wr=%b rdy=%b done=%b err=%b idx=%0d, required all 0 with rdy=1",
                     HADDR, HTRANS, HBURST, HSIZE, HWRITE, rdy, done, err, beat_idx);
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_wrap8_byte();
        logic [15:0] a [8] = '{16'h3C, 16'h3D, 16'h3E, 16'h3F, 16'h38, 16'h39, 16'h3A, 16'h3B};
        int nd, ne;
        for (int i = 0; i < 8; i++) exp_q.push_back(mk(a[i], (i == 0) ? T_NSEQ : T_SEQ, 3'd4, i));
        do_start(16'h3C, 3'd4, 3'd0, 1'b1, 5'd0);
        n_vec++;
        if (HWRITE !== 1'b1 || HSIZE !== 3'd0) begin
            n_bad++;
            $display("FAIL wrap8_ctrl: got wr=%b size=%0d, required wr=1 size=0", HWRITE, HSIZE);
        end
        run_cycles(12, -1, 0, -1, -1, nd, ne);
        n_vec++;
        if (nd !== 1 || ne !== 0 || exp_q.size() !== 0 || rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap8_end: got done=%0d err=%0d left=%0d rdy=%b, required 1 0 0 1", nd, ne, exp_q.size(), rdy);
        end
    endtask

    task automatic test_wrap4_stall();
        logic [15:0] a [4] = '{16'h34, 16'h38, 16'h3C, 16'h30};
        int nd, ne;
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(a[i], (i == 0) ? T_NSEQ : T_SEQ, 3'd2, i));
        do_start(16'h34, 3'd2, 3'd2, 1'b0, 5'd0);
        run_cycles(10, 2, 2, -1, -1, nd, ne);
        n_vec++;
        if (log_addr[2] !== 16'h3C || log_addr[3] !== 16'h3C || log_addr[4] !== 16'h3C ||
            log_trans[3] !== T_SEQ) begin
            n_bad++;
            $display("FAIL wrap4_hold: got %h %h %h trans=%0d, required 3C 3C 3C trans=3",
                     log_addr[2], log_addr[3], log_addr[4], log_trans[3]);
        end
        n_vec++;
        if (nd !== 1 || ne !== 0 || exp_q.size() !== 0 || HWRITE !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap4_end: got done=%0d err=%0d left=%0d wr=%b, required 1 0 0 0", nd, ne, exp_q.size(), HWRITE);
        end
    endtask

    task automatic test_busy();
        int nd, ne;
        exp_q.push_back(mk(16'h10, T_NSEQ, 3'd3, 0));
        exp_q.push_back(mk(16'h12, T_BUSY, 3'd3, 1));
        exp_q.push_back(mk(16'h12, T_SEQ,  3'd3, 1));
        exp_q.push_back(mk(16'h14, T_SEQ,  3'd3, 2));
        exp_q.push_back(mk(16'h16, T_SEQ,  3'd3, 3));
        do_start(16'h10, 3'd3, 3'd1, 1'b1, 5'd0);
        run_cycles(9, -1, 0, 0, -1, nd, ne);
        n_vec++;
        if (nd !== 1 || ne !== 0 || exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL busy_end: got done=%0d err=%0d left=%0d, required 1 0 0", nd, ne, exp_q.size());
        end
    endtask

    task automatic test_error();
        int nd, ne;
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(16'(4 * i), (i == 0) ? T_NSEQ : T_SEQ, 3'd5, i));
        do_start(16'h00, 3'd5, 3'd2, 1'b0, 5'd0);
        run_cycles(8, -1, 0, -1, 3, nd, ne);
        n_vec++;
        if (log_addr[3] !== 16'h0C || log_trans[3] !== T_SEQ || log_trans[4] !== T_IDLE || log_trans[5] !== T_IDLE) begin
            n_bad++;
            $display("FAIL error_trans: got addr3=%h trans3=%0d trans4=%0d trans5=%0d, required 0C 3 0 0",
                     log_addr[3], log_trans[3], log_trans[4], log_trans[5]);
        end
        n_vec++;
        if (nd !== 0 || ne !== 1 || exp_q.size() !== 0 || rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL error_end: got done=%0d err=%0d left=%0d rdy=%b, required 0 1 0 1", nd, ne, exp_q.size(), rdy);
        end
    endtask

    task automatic test_kb_boundary();
        int nd, ne;
        exp_q.push_back(mk(16'h3F8, T_NSEQ, 3'd1, 0));
        exp_q.push_back(mk(16'h3FC, T_SEQ,  3'd1, 1));
`ifdef KB_BOUNDARY_EN
        exp_q.push_back(mk(16'h400, T_NSEQ, 3'd1, 2));
`else
        exp_q.push_back(mk(16'h400, T_SEQ,  3'd1, 2));
`endif
        exp_q.push_back(mk(16'h404, T_SEQ,  3'd1, 3));
        do_start(16'h3F8, 3'd1, 3'd2, 1'b1, 5'd4);
        run_cycles(8, -1, 0, -1, -1, nd, ne);
        n_vec++;
        if (nd !== 1 || ne !== 0 || exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL kb_end: got done=%0d err=%0d left=%0d, required 1 0 0", nd, ne, exp_q.size());
        end
`ifndef KB_BOUNDARY_EN
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(16'h3F8 + 16'(4 * i), (i == 0) ? T_NSEQ : T_SEQ, 3'd3, i));
        do_start(16'h3F8, 3'd3, 3'd2, 1'b1, 5'd0);
        run_cycles(7, -1, 0, -1, -1, nd, ne);
        n_vec++;
        if (nd !== 1 || exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL kb_incr4_end: got done=%0d left=%0d, required 1 0", nd, exp_q.size());
        end
`endif
    endtask

    task automatic test_reset_midburst();
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(16'h100 + 16'(4 * i), (i == 0) ? T_NSEQ : T_SEQ, 3'd7, i));
        begin
            int nd, ne;
            do_start(16'h100, 3'd7, 3'd2, 1'b1, 5'd0);
            run_cycles(5, -1, 0, -1, -1, nd, ne);
        end
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        n_vec++;
        if (HTRANS !== T_IDLE || rdy !== 1'b1 || done !== 1'b0 || err !== 1'b0 || HADDR !== 16'h0 || exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL reset_mid: got trans=%0d rdy=%b done=%b err=%b addr=%h left=%0d, required 0 1 0 0 0000 0",
                     HTRANS, rdy, done, err, HADDR, exp_q.size());
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_illegal();
        do_start(16'h3D, 3'd1, 3'd2, 1'b0, 5'd2);
        @(negedge HCLK);
        n_vec++;
        if (err !== 1'b1 || HTRANS !== T_IDLE || rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL misaligned: got err=%b trans=%0d rdy=%b, required 1 0 1", err, HTRANS, rdy);
        end
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        n_vec++;
        if (err !== 1'b0 || HTRANS !== T_IDLE) begin
            n_bad++;
            $display("FAIL misaligned_pulse: got err=%b trans=%0d, required 0 0", err, HTRANS);
        end
        @(posedge HCLK);
        #1;
        do_start(16'h40, 3'd0, 3'd3, 1'b0, 5'd0);
        @(negedge HCLK);
        n_vec++;
        if (err !== 1'b1 || HTRANS !== T_IDLE) begin
            n_bad++;
            $display("FAIL oversize: got err=%b trans=%0d, required 1 0", err, HTRANS);
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_back_to_back();
        int nd, ne;
        exp_q.push_back(mk(16'h40, T_NSEQ, 3'd0, 0));
        exp_q.push_back(mk(16'h51, T_NSEQ, 3'd1, 0));
        do_start(16'h40, 3'd0, 3'd2, 1'b1, 5'd0);
        // Hold a conflicting request while busy; it must be ignored.
        start_addr = 16'h80;
        start      = 1'b1;
        @(negedge HCLK);
        n_vec++;
        if (rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_rdy: got rdy=%b, required 0", rdy);
        end
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        n_vec++;
        if (done !== 1'b1 || HTRANS !== T_IDLE) begin
            n_bad++;
            $display("FAIL b2b_done: got done=%b trans=%0d, required 1 0", done, HTRANS);
        end
        start = 1'b0;
        @(posedge HCLK);
        #1;
        do_start(16'h51, 3'd1, 3'd0, 1'b0, 5'd0);
        run_cycles(4, -1, 0, -1, -1, nd, ne);
        n_vec++;
        if (nd !== 1 || ne !== 0 || exp_q.size() !== 0 || rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_end: got done=%0d err=%0d left=%0d rdy=%b, required 1 0 0 1", nd, ne, exp_q.size(), rdy);
        end
    endtask

    initial begin
        HRESET     = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        burst      = '0;
        size       = '0;
        write      = 1'b0;
        incr_len   = '0;
        busy_req   = 1'b0;
        HREADY     = 1'b1;
        HRESP      = 1'b0;
        test_reset();
        test_wrap8_byte();
        test_wrap4_stall();
        test_busy();
        test_error();
        test_kb_boundary();
        test_reset_midburst();
        test_illegal();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
